// File: rtl/gcm_pkg.sv
// Shared GCM types for the tag stage: phase codes, 128-bit block type,
// the GHASH reduction constant and the final-block mask helper.
package gcm_pkg;

    typedef logic [0:127] block_t;

    typedef enum logic [2:0] {
        PH_IDLE      = 3'd0,
        PH_AAD_FIRST = 3'd1,
        PH_AAD       = 3'd2,
        PH_CT        = 3'd3,
        PH_CT_LAST   = 3'd4,
        PH_LEN_ONLY  = 3'd5,
        PH_RSVD6     = 3'd6,
        PH_RSVD7     = 3'd7
    } gcm_phase_t;

    // Bit 0 is the MSB, so 0xE1 lands on bits [0:7].
    localparam block_t GF128_R = {8'hE1, 120'h0};

    // Keeps bits [0:r-1] of a final partial block, r = len(C) mod 128.
    function automatic block_t ct_mask(input logic [63:0] len_bits);
        logic [6:0] r;
        block_t     ones;
        r    = 7'(len_bits % 64'd128);
        ones = '1;
        if (r == 7'd0) begin
            return ones;
        end
        return ~(ones >> r);
    endfunction

endpackage

// File: rtl/gf128_digit_mul.sv
// One combinational slice of the shift/reduce GF(2^128) multiplier:
// consumes DIGIT_BITS bits of X and advances the Z/V pair that many steps.
module gf128_digit_mul
    import gcm_pkg::*;
#(
    parameter int DIGIT_BITS = 8
) (
    input  logic [0:127]            i_z,
    input  logic [0:127]            i_v,
    input  logic [0:DIGIT_BITS-1]   i_x,
    output logic [0:127]            o_z,
    output logic [0:127]            o_v
);

    block_t w_z;
    block_t w_v;

    always_comb begin
        w_z = i_z;
        w_v = i_v;
        for (int i = 0; i < DIGIT_BITS; i++) begin
            if (i_x[i]) begin
                w_z = w_z ^ w_v;
            end
            // Right shift moves toward higher bit index; bit 127 falls off into R.
            if (w_v[127]) begin
                w_v = (w_v >> 1) ^ GF128_R;
            end else begin
                w_v = w_v >> 1;
            end
        end
    end

    assign o_z = w_z;
    assign o_v = w_v;

endmodule

// File: rtl/ghash_tag_stage.sv
// GHASH accumulator and GCM tag generator behind the AES round pipeline.
// Optional macro GHASH_LAST_BLOCK_MASK_EN zeroes the unused tail of the CT_LAST block.
module ghash_tag_stage
    import gcm_pkg::*;
#(
    parameter int DIGIT_BITS = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic [2:0]    i_phase,
    input  logic [0:127]  i_cipher_text,
    input  logic [0:127]  i_aad,
    input  logic [0:127]  i_h,
    input  logic [0:127]  i_encrypted_j0,
    input  logic [0:127]  i_instance_size,
    output logic [0:127]  o_cipher_text,
    output logic          o_ct_valid,
    output logic [0:127]  o_tag,
    output logic          o_tag_valid,
    output logic          o_err
);

    localparam int         L        = 128 / DIGIT_BITS;
    localparam logic [6:0] LAST_CNT = 7'(L - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_LEN  = 2'd2,
        S_TAG  = 2'd3
    } state_t;

    state_t     r_state;
    state_t     w_state_next;
    gcm_phase_t w_phase;

    block_t     r_y, r_h, r_j0, r_size;
    block_t     r_z, r_v, r_x;
    block_t     r_ct, r_tag;
    logic [6:0] r_cnt;
    logic       r_last, r_session;
    logic       r_ct_valid, r_tag_valid, r_err;

    logic       w_accept, w_step_done;
    logic       w_start_mul, w_start_len, w_ct_accept, w_err;
    block_t     w_ct_masked, w_block, w_z_next, w_v_next;

    assign w_phase     = gcm_phase_t'(i_phase);
    assign o_ready     = (r_state == S_IDLE) && !rst;
    assign w_accept    = i_valid && o_ready;
    assign w_step_done = (r_cnt == LAST_CNT);

`ifdef GHASH_LAST_BLOCK_MASK_EN
    assign w_ct_masked = (w_phase == PH_CT_LAST)
                       ? (i_cipher_text & ct_mask(i_instance_size[64:127]))
                       : i_cipher_text;
`else
    assign w_ct_masked = i_cipher_text;
`endif

    assign w_block = ((w_phase == PH_CT) || (w_phase == PH_CT_LAST)) ? w_ct_masked : i_aad;

    gf128_digit_mul #(
        .DIGIT_BITS (DIGIT_BITS)
    ) u_mul (
        .i_z (r_z),
        .i_v (r_v),
        .i_x (r_x[0:DIGIT_BITS-1]),
        .o_z (w_z_next),
        .o_v (w_v_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_start_mul  = 1'b0;
        w_start_len  = 1'b0;
        w_ct_accept  = 1'b0;
        w_err        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    case (w_phase)
                        PH_AAD_FIRST: begin
                            w_start_mul  = 1'b1;
                            w_state_next = S_MUL;
                        end
                        PH_AAD: begin
                            if (r_session) begin
                                w_start_mul  = 1'b1;
                                w_state_next = S_MUL;
                            end else begin
                                w_err = 1'b1;
                            end
                        end
                        PH_CT, PH_CT_LAST: begin
                            if (r_session) begin
                                w_start_mul  = 1'b1;
                                w_ct_accept  = 1'b1;
                                w_state_next = S_MUL;
                            end else begin
                                w_err = 1'b1;
                            end
                        end
                        PH_LEN_ONLY: begin
                            if (r_session) begin
                                w_start_len  = 1'b1;
                                w_state_next = S_LEN;
                            end else begin
                                w_err = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            S_MUL: begin
                if (w_step_done) begin
                    w_state_next = r_last ? S_LEN : S_IDLE;
                end
            end
            S_LEN: begin
                if (w_step_done) begin
                    w_state_next = S_TAG;
                end
            end
            S_TAG: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_y         <= '0;
            r_h         <= '0;
            r_j0        <= '0;
            r_size      <= '0;
            r_z         <= '0;
            r_v         <= '0;
            r_x         <= '0;
            r_cnt       <= '0;
            r_last      <= 1'b0;
            r_session   <= 1'b0;
            r_ct        <= '0;
            r_ct_valid  <= 1'b0;
            r_tag       <= '0;
            r_tag_valid <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_ct_valid  <= 1'b0;
            r_tag_valid <= 1'b0;
            r_err       <= w_err;

            if (w_ct_accept) begin
                r_ct       <= w_ct_masked;
                r_ct_valid <= 1'b1;
            end

            if (r_state == S_TAG) begin
                r_session <= 1'b0;
            end

            if (w_start_mul) begin
                r_z    <= '0;
                r_cnt  <= '0;
                r_last <= (w_phase == PH_CT_LAST);
                if (w_phase == PH_AAD_FIRST) begin
                    // A new session starts from Y = 0, so X is just the AAD block.
                    r_session <= 1'b1;
                    r_h       <= i_h;
                    r_j0      <= i_encrypted_j0;
                    r_size    <= i_instance_size;
                    r_y       <= '0;
                    r_x       <= i_aad;
                    r_v       <= i_h;
                end else begin
                    r_x <= r_y ^ w_block;
                    r_v <= r_h;
                end
            end else if (w_start_len) begin
                r_z    <= '0;
                r_cnt  <= '0;
                r_x    <= r_y ^ r_size;
                r_v    <= r_h;
                r_last <= 1'b0;
            end else if ((r_state == S_MUL) || (r_state == S_LEN)) begin
                r_z   <= w_z_next;
                r_v   <= w_v_next;
                r_x   <= r_x << DIGIT_BITS;
                r_cnt <= r_cnt + 7'd1;
                if (w_step_done) begin
                    r_y <= w_z_next;
                    if (r_state == S_LEN) begin
                        r_tag       <= w_z_next ^ r_j0;
                        r_tag_valid <= 1'b1;
                    end else if (r_last) begin
                        // Chain straight into the length block using the fresh Y.
                        r_z    <= '0;
                        r_cnt  <= '0;
                        r_x    <= w_z_next ^ r_size;
                        r_v    <= r_h;
                        r_last <= 1'b0;
                    end
                end
            end
        end
    end

    assign o_cipher_text = r_ct;
    assign o_ct_valid    = r_ct_valid;
    assign o_tag         = r_tag;
    assign o_tag_valid   = r_tag_valid;
    assign o_err         = r_err;

endmodule
